inst_fetch: RTL

Instruction-fetch stage directly upstream of the memory controller's IF port, holding the PC and a direct-mapped instruction cache. On a cache hit it delivers the instruction to decode without touching memory. On a miss it raises a fetch request to the memory controller, waits for the one-cycle completion pulse, fills the cache and delivers. It also handles downstream stall and jump redirect.

---
 rtl/inst_fetch.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/inst_fetch.sv
// inst_fetch: instruction-fetch stage with the PC and a direct-mapped,
// one-word-per-line instruction cache, sitting upstream of the memory
// controller's IF port.
//
// A hit delivers to decode one cycle after lookup, one instruction per
// cycle. A miss raises mc_request with mc_addr held until the one-cycle
// mc_enable pulse. The returned word is written into the cache and
// delivered on the same edge. A jump redirects the PC at once. A fetch
// that is still in flight when a jump arrives cannot be cancelled, so it
// completes into the cache and is not delivered.
//
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   rdy          global enable; when low every register holds
//   stall        decode cannot accept; held id_* stay stable
//   jump_en      redirect the PC to jump_addr (word aligned)
//   mc_addr      fetch address to the memory controller
//   mc_request   fetch request to the memory controller
//   mc_inst      fetched word, valid with mc_enable
//   mc_enable    one-cycle fetch-complete pulse
//   id_pc        PC of the delivered instruction
//   id_inst      delivered instruction
//   id_valid     id_pc/id_inst valid
module inst_fetch #(
    parameter int ADDR_LEN   = 32,
    parameter int INST_LEN   = 32,
    parameter int INDEX_BITS = 7
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rdy,
    input  logic                stall,
    input  logic                jump_en,
    input  logic [ADDR_LEN-1:0] jump_addr,
    output logic [ADDR_LEN-1:0] mc_addr,
    output logic                mc_request,
    input  logic [INST_LEN-1:0] mc_inst,
    input  logic                mc_enable,
    output logic [ADDR_LEN-1:0] id_pc,
    output logic [INST_LEN-1:0] id_inst,
    output logic                id_valid
);

    localparam int LINES    = 1 << INDEX_BITS;
    localparam int TAG_BITS = ADDR_LEN - INDEX_BITS - 2;
    localparam logic [ADDR_LEN-1:0] PC_STEP = ADDR_LEN'(32'd4);

    typedef enum logic [1:0] {
        S_RUN     = 2'd0,
        S_WAIT    = 2'd1,
        S_DISCARD = 2'd2
    } state_t;

    state_t                state_r, state_s;
    logic [ADDR_LEN-1:0]   pc_r, pc_s;
    logic [LINES-1:0]      valid_r;
    logic [TAG_BITS-1:0]   tag_mem_r  [LINES];
    logic [INST_LEN-1:0]   data_mem_r [LINES];

    logic [INDEX_BITS-1:0] pc_index_s, fill_index_s;
    logic [TAG_BITS-1:0]   pc_tag_s, fill_tag_s;
    logic                  hit_s, accept_s, fill_s;
    logic [ADDR_LEN-1:0]   mc_addr_s, id_pc_s;
    logic [INST_LEN-1:0]   id_inst_s;
    logic                  mc_request_s, id_valid_s;

    // Cache lookup for the current PC; the fill always targets the held mc_addr.
    always_comb begin
        pc_index_s   = pc_r[INDEX_BITS+1:2];
        pc_tag_s     = pc_r[ADDR_LEN-1:INDEX_BITS+2];
        fill_index_s = mc_addr[INDEX_BITS+1:2];
        fill_tag_s   = mc_addr[ADDR_LEN-1:INDEX_BITS+2];
        hit_s        = valid_r[pc_index_s] && (tag_mem_r[pc_index_s] == pc_tag_s);
        accept_s     = !stall || !id_valid;
    end

    // Next-state, next-PC and next-output logic; every value holds unless changed.
    always_comb begin
        state_s      = state_r;
        pc_s         = pc_r;
        mc_request_s = mc_request;
        mc_addr_s    = mc_addr;
        id_valid_s   = id_valid;
        id_pc_s      = id_pc;
        id_inst_s    = id_inst;
        fill_s       = 1'b0;
        case (state_r)
            S_RUN: begin
                if (jump_en) begin
                    pc_s       = jump_addr;
                    id_valid_s = 1'b0;
                end else if (accept_s) begin
                    if (hit_s) begin
                        id_valid_s = 1'b1;
                        id_pc_s    = pc_r;
                        id_inst_s  = data_mem_r[pc_index_s];
                        pc_s       = pc_r + PC_STEP;
                    end else begin
                        mc_addr_s    = pc_r;
                        mc_request_s = 1'b1;
                        id_valid_s   = 1'b0;
                        state_s      = S_WAIT;
                    end
                end else begin
                    pc_s = pc_r;
                end
            end
            S_WAIT, S_DISCARD: begin
                if (mc_enable) begin
                    // The fill happens even after a redirect: the bus cycle cannot be aborted.
                    fill_s       = 1'b1;
                    mc_request_s = 1'b0;
                    state_s      = S_RUN;
                    if (!jump_en && (state_r == S_WAIT) && accept_s) begin
                        id_valid_s = 1'b1;
                        id_pc_s    = mc_addr;
                        id_inst_s  = mc_inst;
                        pc_s       = pc_r + PC_STEP;
                    end else begin
                        pc_s = pc_r;
                    end
                end else if (jump_en) begin
                    state_s = S_DISCARD;
                end else begin
                    state_s = state_r;
                end
                if (jump_en) begin
                    pc_s       = jump_addr;
                    id_valid_s = 1'b0;
                end else begin
                    id_valid_s = id_valid_s;
                end
            end
            default: begin
                state_s      = S_RUN;
                mc_request_s = 1'b0;
                id_valid_s   = 1'b0;
            end
        endcase
    end

    // State, PC, valid bits and output registers; frozen while rdy is low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= S_RUN;
            pc_r       <= '0;
            valid_r    <= '0;
            mc_request <= 1'b0;
            mc_addr    <= '0;
            id_valid   <= 1'b0;
            id_pc      <= '0;
            id_inst    <= '0;
        end else if (rdy) begin
            state_r    <= state_s;
            pc_r       <= pc_s;
            mc_request <= mc_request_s;
            mc_addr    <= mc_addr_s;
            id_valid   <= id_valid_s;
            id_pc      <= id_pc_s;
            id_inst    <= id_inst_s;
            if (fill_s) begin
                valid_r[fill_index_s] <= 1'b1;
            end
        end
    end

    // Tag and data storage; contents are qualified by valid_r, so no reset is needed.
    always_ff @(posedge clk) begin
        if (rdy && fill_s) begin
            tag_mem_r[fill_index_s]  <= fill_tag_s;
            data_mem_r[fill_index_s] <= mc_inst;
        end
    end

endmodule
